// File: rtl/weight_fetch.sv
// Weight-memory read master: fetches num_words words starting at base_addr and
// streams them in order to the PE array through a credit-limited return FIFO.
module weight_fetch #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_weight,
  output logic              read_weight,
  input  logic              waitrequest_weight,
  input  logic [DATA_W-1:0] readdata_weight,
  input  logic              readdatavalid_weight,
  output logic [DATA_W-1:0] wdata_out,
  output logic              wvalid_out,
  input  logic              wready_in
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] issue_left_reg, issue_left_next;
  logic [ADDR_W-1:0] deliver_left_reg, deliver_left_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [CNT_W-1:0]  in_use;
  logic              accept, push, pop, last_pop;

  // Every slot is either holding data or reserved for a read still in flight.
  assign in_use      = fifo_count_reg + outstanding_reg;
  assign read_weight = (state_reg == ISSUE) && (issue_left_reg != '0) &&
                       (in_use < CNT_W'(FIFO_DEPTH));
  assign accept      = read_weight && !waitrequest_weight;
  assign push        = readdatavalid_weight && (state_reg != IDLE);
  assign wvalid_out  = (fifo_count_reg != '0);
  assign pop         = wvalid_out && wready_in;
  assign last_pop    = pop && (state_reg == DRAIN) && (deliver_left_reg == ADDR_W'(1));

  assign wdata_out      = wvalid_out ? fifo_mem[rd_ptr_reg] : '0;
  assign address_weight = addr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    issue_left_next   = issue_left_reg;
    deliver_left_next = deliver_left_reg;
    outstanding_next  = outstanding_reg;
    fifo_count_next   = fifo_count_reg;
    done_next         = 1'b0;
    busy_next         = busy_reg;

    // busy covers the done cycle and falls one cycle later
    if (done_reg) busy_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next         = base_addr;
          issue_left_next   = num_words;
          deliver_left_next = num_words;
          if (num_words == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ISSUE;
            busy_next  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_next       = addr_reg + ADDR_W'(1);
          issue_left_next = issue_left_reg - ADDR_W'(1);
          if (issue_left_reg == ADDR_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (pop) deliver_left_next = deliver_left_reg - ADDR_W'(1);

    unique case ({accept, push})
      2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
      2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
      default: outstanding_next = outstanding_reg;
    endcase

    unique case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
      2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      issue_left_reg   <= '0;
      deliver_left_reg <= '0;
      outstanding_reg  <= '0;
      fifo_count_reg   <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      done_reg         <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      issue_left_reg   <= issue_left_next;
      deliver_left_reg <= deliver_left_next;
      outstanding_reg  <= outstanding_next;
      fifo_count_reg   <= fifo_count_next;
      done_reg         <= done_next;
      busy_reg         <= busy_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // Storage needs no reset: the output is gated by wvalid_out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= readdata_weight;
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: negedge memory model with configurable read
// latency, stream monitor, and one task per scenario with inline checks.
module tb_weight_fetch;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] address_weight;
  logic              read_weight;
  logic              waitrequest_weight = 1'b0;
  logic [DATA_W-1:0] readdata_weight = '0;
  logic              readdatavalid_weight = 1'b0;
  logic [DATA_W-1:0] wdata_out;
  logic              wvalid_out;
  logic              wready_in = 1'b0;

  weight_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .address_weight(address_weight), .read_weight(read_weight),
    .waitrequest_weight(waitrequest_weight), .readdata_weight(readdata_weight),
    .readdatavalid_weight(readdatavalid_weight), .wdata_out(wdata_out),
    .wvalid_out(wvalid_out), .wready_in(wready_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  int cyc = 0;

  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];
  logic [ADDR_W-1:0] acc_addr[$];
  int                acc_cyc[$];
  logic [DATA_W-1:0] got[$];
  int                pop_cyc[$];
  int done_cnt, done_cyc, wvalid_cnt, busy_cnt, rdv_cnt;

  function automatic logic [DATA_W-1:0] mkword(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++)
      w[i*32 +: 32] = ({15'd0, a} * 32'd2654435761) ^ (32'(i) << 24) ^ 32'(i + 1);
    return w;
  endfunction

  // Memory model and stream monitor, all on the falling edge.
  always @(negedge clk) begin
    readdatavalid_weight = 1'b0;
    readdata_weight      = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      readdatavalid_weight = 1'b1;
      readdata_weight      = mkword(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      rdv_cnt++;
    end
    if (read_weight && !waitrequest_weight) begin
      pend_addr.push_back(address_weight);
      pend_due.push_back(cyc + lat);
      acc_addr.push_back(address_weight);
      acc_cyc.push_back(cyc);
    end
    if (wvalid_out) wvalid_cnt++;
    if (wvalid_out && wready_in) begin
      got.push_back(wdata_out);
      pop_cyc.push_back(cyc);
      $display("[cyc %0d] word delivered low=%h", cyc, wdata_out[63:0]);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete(); got.delete(); pop_cyc.delete();
    done_cnt = 0; done_cyc = -1; wvalid_cnt = 0; busy_cnt = 0; rdv_cnt = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (read_weight !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", read_weight); end
    n_cmp++; if (address_weight !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", address_weight); end
    n_cmp++; if (wvalid_out !== 1'b0) begin n_err++; $display("FAIL reset_wvalid: got %b want 0", wvalid_out); end
    n_cmp++; if (wdata_out !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", wdata_out[63:0]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] a;
    clear_logs(); lat = 1; wready_in = 1'b1;
    base_addr = 17'h00010; num_words = 17'd3; start = 1'b1;
    tick();
    // start still high with other operands: ignored outside IDLE
    base_addr = 17'h00999; num_words = 17'd7;
    n_cmp++; if ({read_weight, address_weight} !== {1'b1, 17'h00010}) begin
      n_err++; $display("FAIL basic_first_read: got rd=%b addr=%h want rd=1 addr=00010", read_weight, address_weight); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    tick();
    start = 1'b0;
    wait_done(50, "basic");
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_in_done: got %b want 1", busy); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy); end
    repeat (3) tick();
    n_cmp++; if (acc_addr.size() != 3) begin n_err++; $display("FAIL basic_read_count: got %0d want 3", acc_addr.size()); end
    for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
      a = 17'h00010 + 17'(i);
      n_cmp++; if (acc_addr[i] !== a || acc_cyc[i] != acc_cyc[0] + i) begin
        n_err++; $display("FAIL basic_read_%0d: got addr=%h cyc+%0d want addr=%h cyc+%0d", i, acc_addr[i], acc_cyc[i] - acc_cyc[0], a, i); end
    end
    n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL basic_word_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      a = 17'h00010 + 17'(i);
      n_cmp++; if (got[i] !== mkword(a)) begin
        n_err++; $display("FAIL basic_word_%0d: got %h want %h", i, got[i][63:0], mkword(a) & 64'hFFFFFFFFFFFFFFFF); end
    end
    if (got.size() == 3 && acc_addr.size() == 3) begin
      n_cmp++; if (pop_cyc[0] - acc_cyc[0] != 2) begin
        n_err++; $display("FAIL basic_latency: got %0d cycles want 2", pop_cyc[0] - acc_cyc[0]); end
      n_cmp++; if (done_cyc - pop_cyc[2] != 1) begin
        n_err++; $display("FAIL basic_done_timing: got %0d cycles after last pop want 1", done_cyc - pop_cyc[2]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    $display("basic job finished: %0d reads, %0d words", acc_addr.size(), got.size());
  endtask

  task automatic test_zero();
    clear_logs(); lat = 1; wready_in = 1'b1;
    base_addr = 17'h00055; num_words = 17'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({done, busy, read_weight} !== 3'b100) begin
      n_err++; $display("FAIL zero_done_cycle: got done=%b busy=%b rd=%b want 1 0 0", done, busy, read_weight); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width: got %b want 0", done); end
    repeat (8) tick();
    n_cmp++; if (acc_addr.size() != 0) begin n_err++; $display("FAIL zero_reads: got %0d want 0", acc_addr.size()); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt); end
    $display("zero-length job finished");
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    clear_logs(); lat = 2; wready_in = 1'b0;
    base_addr = 17'h00100; num_words = 17'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_cmp++; if (acc_addr.size() != 4) begin n_err++; $display("FAIL bp_reads_stalled: got %0d want 4", acc_addr.size()); end
    n_cmp++; if (read_weight !== 1'b0) begin n_err++; $display("FAIL bp_read_low: got %b want 0", read_weight); end
    n_cmp++; if (wvalid_out !== 1'b1) begin n_err++; $display("FAIL bp_wvalid: got %b want 1", wvalid_out); end
    n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL bp_no_pop: got %0d want 0", got.size()); end
    wready_in = 1'b1;
    wait_done(100, "bp");
    repeat (3) tick();
    n_cmp++; if (acc_addr.size() != 8) begin n_err++; $display("FAIL bp_read_count: got %0d want 8", acc_addr.size()); end
    n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL bp_word_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      a = 17'h00100 + 17'(i);
      n_cmp++; if (got[i] !== mkword(a)) begin
        n_err++; $display("FAIL bp_word_%0d: got %h want %h", i, got[i][63:0], mkword(a) & 64'hFFFFFFFFFFFFFFFF); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    $display("back-pressure job finished: %0d words", got.size());
  endtask

  task automatic test_waitrequest();
    logic [ADDR_W-1:0] a;
    clear_logs(); lat = 1; wready_in = 1'b1;
    base_addr = 17'h00200; num_words = 17'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    waitrequest_weight = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({read_weight, address_weight} !== {1'b1, 17'h00201}) begin
        n_err++; $display("FAIL wr_hold_%0d: got rd=%b addr=%h want rd=1 addr=00201", i, read_weight, address_weight); end
      tick();
    end
    waitrequest_weight = 1'b0;
    wait_done(50, "wr");
    repeat (3) tick();
    n_cmp++; if (acc_addr.size() != 4) begin n_err++; $display("FAIL wr_read_count: got %0d want 4", acc_addr.size()); end
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      a = 17'h00200 + 17'(i);
      n_cmp++; if (acc_addr[i] !== a) begin n_err++; $display("FAIL wr_addr_%0d: got %h want %h", i, acc_addr[i], a); end
    end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL wr_word_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      a = 17'h00200 + 17'(i);
      n_cmp++; if (got[i] !== mkword(a)) begin
        n_err++; $display("FAIL wr_word_%0d: got %h want %h", i, got[i][63:0], mkword(a) & 64'hFFFFFFFFFFFFFFFF); end
    end
    $display("waitrequest job finished: %0d words", got.size());
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] a;
    clear_logs(); lat = 1; wready_in = 1'b1;
    base_addr = 17'h1FFFE; num_words = 17'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, "wrap");
    repeat (3) tick();
    n_cmp++; if (acc_addr.size() != 4) begin n_err++; $display("FAIL wrap_read_count: got %0d want 4", acc_addr.size()); end
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      a = 17'h1FFFE + 17'(i);
      n_cmp++; if (acc_addr[i] !== a) begin n_err++; $display("FAIL wrap_addr_%0d: got %h want %h", i, acc_addr[i], a); end
    end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL wrap_word_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      a = 17'h1FFFE + 17'(i);
      n_cmp++; if (got[i] !== mkword(a)) begin
        n_err++; $display("FAIL wrap_word_%0d: got %h want %h", i, got[i][63:0], mkword(a) & 64'hFFFFFFFFFFFFFFFF); end
    end
    $display("wrap job finished: %0d words", got.size());
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 17'h00600; exp_a[1] = 17'h00601; exp_a[2] = 17'h00700; exp_a[3] = 17'h00701;
    clear_logs(); lat = 1; wready_in = 1'b1;
    base_addr = 17'h00600; num_words = 17'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, "b2b_first");
    base_addr = 17'h00700; num_words = 17'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({busy, read_weight, address_weight} !== {1'b1, 1'b1, 17'h00700}) begin
      n_err++; $display("FAIL b2b_restart: got busy=%b rd=%b addr=%h want 1 1 00700", busy, read_weight, address_weight); end
    wait_done(50, "b2b_second");
    repeat (3) tick();
    n_cmp++; if (acc_addr.size() != 4) begin n_err++; $display("FAIL b2b_read_count: got %0d want 4", acc_addr.size()); end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL b2b_word_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== mkword(exp_a[i])) begin
        n_err++; $display("FAIL b2b_word_%0d: got %h want %h", i, got[i][63:0], mkword(exp_a[i]) & 64'hFFFFFFFFFFFFFFFF); end
    end
    n_cmp++; if (done_cnt != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    $display("back-to-back jobs finished: %0d words", got.size());
  endtask

  task automatic test_reset_midjob();
    logic [ADDR_W-1:0] a;
    int k = 0;
    clear_logs(); lat = 3; wready_in = 1'b1;
    base_addr = 17'h00300; num_words = 17'd6; start = 1'b1;
    tick();
    start = 1'b0;
    while (got.size() < 2 && k < 100) begin tick(); k++; end
    n_cmp++; if (got.size() < 2) begin n_err++; $display("FAIL mid_progress: got %0d words want >=2", got.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy, done, read_weight, wvalid_out} !== 4'b0000) begin
      n_err++; $display("FAIL mid_reset_ctrl: got busy=%b done=%b rd=%b wv=%b want 0 0 0 0", busy, done, read_weight, wvalid_out); end
    n_cmp++; if (address_weight !== '0) begin n_err++; $display("FAIL mid_reset_addr: got %h want 0", address_weight); end
    n_cmp++; if (wdata_out !== '0) begin n_err++; $display("FAIL mid_reset_wdata: got %h want 0", wdata_out[63:0]); end
    clear_logs();
    repeat (10) tick();
    n_cmp++; if (wvalid_cnt != 0) begin n_err++; $display("FAIL mid_stale_wvalid: got %0d cycles want 0", wvalid_cnt); end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL mid_busy_after_reset: got %0d want 0", busy_cnt); end
    n_cmp++; if ((rdv_cnt > 0) !== 1'b1) begin n_err++; $display("FAIL mid_stale_returns_seen: got %0d want >0", rdv_cnt); end
    clear_logs(); lat = 1;
    base_addr = 17'h00040; num_words = 17'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, "mid_restart");
    repeat (3) tick();
    n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL mid_restart_count: got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      a = 17'h00040 + 17'(i);
      n_cmp++; if (got[i] !== mkword(a)) begin
        n_err++; $display("FAIL mid_restart_word_%0d: got %h want %h", i, got[i][63:0], mkword(a) & 64'hFFFFFFFFFFFFFFFF); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL mid_restart_done: got %0d want 1", done_cnt); end
    $display("reset mid-job and restart finished: %0d words", got.size());
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_waitrequest();
    test_wrap();
    test_back_to_back();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_fetch.md
Name: weight_fetch

Overview:
- Downstream neighbour of the DMA-to-weight-memory packer. Reads 1024-bit weight words back out of the on-chip weight memory through an Avalon-MM read master with variable read latency.
- Presents the words in order to the PE array over a valid/ready stream.
- The controller supplies a base address and a word count per job.
- A small credit-limited FIFO absorbs read latency and PE back-pressure.

Parameters:
- DATA_W, 1024, weight word width (memory data and stream data).
- ADDR_W, 17, weight memory word-address width.
- FIFO_DEPTH, 4, return-data FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request from controller.
- base_addr  in  ADDR_W  first word address; sampled on accepted start.
- num_words  in  ADDR_W  words to fetch; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- address_weight  out  ADDR_W  read address to weight memory.
- read_weight  out  1  read request.
- waitrequest_weight  in  1  memory stall; request held while high.
- readdata_weight  in  DATA_W  returned word.
- readdatavalid_weight  in  1  readdata_weight valid this cycle.
- wdata_out  out  DATA_W  word to PE array.
- wvalid_out  out  1  wdata_out valid.
- wready_in  in  1  PE array accepts the word when wvalid_out && wready_in.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following. All counters and FIFO pointers go to 0.
  - busy=0, done=0, read_weight=0, address_weight=0, wvalid_out=0, wdata_out=0, state=IDLE.
  - Reset mid-job aborts the job with no done pulse.
  - readdatavalid_weight is ignored in IDLE, so stale returns after a reset are dropped.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 latches base_addr into the address counter, num_words into issue_left and deliver_left.
  - If num_words=0: stay IDLE, assert done for exactly one cycle on the next cycle, issue no reads, keep busy low.
  - Otherwise go to ISSUE.
  - start is ignored in any state other than IDLE.
- Credit rule: credits = FIFO_DEPTH - (fifo_count + outstanding). read_weight is asserted only when issue_left>0 and credits>0, so the FIFO never overflows.
- Read handshake:
  - A read is accepted when read_weight && !waitrequest_weight.
  - While waitrequest_weight=1, address_weight and read_weight hold stable.
  - On accept: address +1 (mod 2^ADDR_W, wraps 0x1FFFF -> 0x00000), issue_left -1, outstanding +1.
  - First read_weight assertion is the cycle after the accepted start.
- Returns:
  - readdatavalid_weight pushes readdata_weight into the FIFO and sets outstanding -1.
  - A simultaneous accept and return leaves outstanding unchanged.
  - Returns are assumed in-order.
- ISSUE -> DRAIN when the last read is accepted (issue_left goes 1 -> 0).
- Stream output:
  - wvalid_out = FIFO not empty; wdata_out = FIFO head.
  - Pop on wvalid_out && wready_in; deliver_left -1.
  - Simultaneous push and pop in the same cycle keeps fifo_count unchanged.
  - Empty FIFO: wvalid_out=0. Full FIFO is impossible to overflow by the credit rule.
- DRAIN -> IDLE on the pop that takes deliver_left 1 -> 0.
  - done=1 in that same cycle (registered, so the pulse is visible on the following edge); busy drops the cycle after.
- Minimum latency, zero waitrequest, memory read latency L: first wvalid_out is L+1 cycles after the first read accept (one FIFO register stage).
- Throughput: one word per cycle sustained when L+1 <= FIFO_DEPTH and wready_in=1.

Test Plan:
- Basic, L=1, no stalls: start, base_addr=0x00010, num_words=3.
  - Reads to 0x10, 0x11, 0x12 on consecutive cycles.
  - Stream delivers the three words in order; single done pulse; busy low afterwards.
- num_words=0: start -> no read_weight ever; done pulses once the next cycle; busy stays 0.
- Back-pressure: num_words=8, wready_in=0 for 20 cycles, L=2.
  - Exactly FIFO_DEPTH=4 reads issued, then read_weight=0.
  - After wready_in=1, all 8 words arrive in order, no loss or duplication.
- waitrequest: waitrequest_weight=1 for 5 cycles on the second read.
  - address_weight holds base+1 with read_weight=1 throughout; resumes afterwards; data order intact.
- Wrap: base_addr=0x1FFFE, num_words=4 -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset mid-job: rst for 1 cycle after 2 of 6 words delivered, with returns still in flight.
  - All outputs go to reset values; no done pulse; late readdatavalid pulses produce no wvalid_out.
  - A new start then works normally.
